// File: rtl/tick_interval_monitor.sv
// Tick-to-tick interval monitor: locks onto a periodic tick, flags early/missing ticks, divides locked ticks.
// Optional miss counter is built when MISS_CNT_EN is defined; otherwise miss_cnt is tied to zero.
//
// state  | meaning
// IDLE   | monitor disabled, gap held at zero
// ACQ    | waiting for a first tick, no window checks
// TRACK  | counting consecutive good intervals toward lock
// LOCKED | locked; good ticks drive the divider
// FAULT  | early or missing tick while locked; sticky until clr_err
module tick_interval_monitor #(
  parameter int PERIOD   = 400001,
  parameter int TOL      = 2,
  parameter int CBITS    = 19,
  parameter int LOCK_CNT = 4,
  parameter int DIV      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             flg,
  output logic             div_out,
  output logic [CBITS-1:0] gap,
  output logic [7:0]       miss_cnt
);

  typedef enum logic [2:0] {IDLE, ACQ, TRACK, LOCKED, FAULT} state_t;

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam int DBITS = $clog2(DIV + 1);

  // Window bounds carry one extra bit so gap+1 never wraps at saturation.
  localparam logic [CBITS:0] WIN_LO = (CBITS+1)'(PERIOD - TOL);
  localparam logic [CBITS:0] WIN_HI = (CBITS+1)'(PERIOD + TOL);
  localparam logic [CBITS:0] WIN_TO = (CBITS+1)'(PERIOD + TOL + 1);
  localparam logic [GBITS-1:0] LOCK_LAST = GBITS'(LOCK_CNT - 1);
  localparam logic [DBITS-1:0] DIV_LAST  = DBITS'(DIV - 1);

  state_t           state;
  logic [GBITS-1:0] good;
  logic [DBITS-1:0] divcnt;
  logic [CBITS:0]   interval;
  logic             early;
  logic             in_win;
  logic             timeout;

  assign interval = {1'b0, gap} + {{CBITS{1'b0}}, 1'b1};
  assign early    = tick & (interval < WIN_LO);
  assign in_win   = tick & (interval >= WIN_LO) & (interval <= WIN_HI);
  assign timeout  = ~tick & (interval == WIN_TO);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state   <= IDLE;
      gap     <= '0;
      good    <= '0;
      divcnt  <= '0;
      div_out <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      flg     <= 1'b0;
    end else begin
      flg <= 1'b0;
      if (tick)
        gap <= '0;
      else if (!(&gap))
        gap <= gap + CBITS'(1);

      case (state)
        IDLE: begin
          gap   <= '0;
          state <= ACQ;
        end
        ACQ: begin
          if (tick) begin
            state <= TRACK;
            good  <= '0;
          end
        end
        TRACK: begin
          if (early || timeout) begin
            state <= ACQ;
            good  <= '0;
          end else if (in_win) begin
            flg  <= 1'b1;
            good <= good + GBITS'(1);
            if (good == LOCK_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              divcnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (early || timeout) begin
            state  <= FAULT;
            locked <= 1'b0;
            err    <= 1'b1;
          end else if (in_win) begin
            flg <= 1'b1;
            if (divcnt == DIV_LAST) begin
              div_out <= ~div_out;
              divcnt  <= '0;
            end else begin
              divcnt <= divcnt + DBITS'(1);
            end
          end
        end
        FAULT: begin
          // A tick arriving with clr_err only restarts gap; ACQ still waits for a fresh tick.
          if (clr_err) begin
            state <= ACQ;
            err   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISS_CNT_EN
  logic miss_evt;

  assign miss_evt = en & ((state == TRACK) | (state == LOCKED)) & (early | timeout);

  always_ff @(posedge clk) begin
    if (rst)
      miss_cnt <= 8'd0;
    else if (miss_evt && (miss_cnt != 8'hff))
      miss_cnt <= miss_cnt + 8'd1;
  end
`else
  assign miss_cnt = 8'd0;
`endif

endmodule
